// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block: register map, sequencer states, table entry layout.
package pwm_pkg;

    // PWM register file map (6-bit address space)
    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_PERIOD   = 6'h01;
    localparam logic [5:0] REG_PRESCALE = 6'h02;
    localparam logic [5:0] REG_COMPARE1 = 6'h03;
    localparam logic [5:0] REG_DEADTIME = 6'h04;
    localparam logic [5:0] REG_COMPARE2 = 6'h05;
    localparam logic [5:0] REG_STATUS   = 6'h06;

    typedef enum logic [1:0] {
        StIdle,
        StWrC1,
        StWrC2,
        StWaitWrap
    } seq_state_e;

    typedef struct packed {
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] rep;
    } tbl_entry_t;

    function automatic tbl_entry_t pack_entry(input logic [7:0] c1, input logic [7:0] c2,
                                              input logic [7:0] rep);
        tbl_entry_t e;
        e.c1  = c1;
        e.c2  = c2;
        e.rep = rep;
        return e;
    endfunction

endpackage

// File: rtl/pwm_seq_table.sv
// Profile table: DEPTH entries of {c1, c2, rep}, one write port, asynchronous read.
module pwm_seq_table
    import pwm_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  tbl_entry_t       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output tbl_entry_t       rd_data
);

    tbl_entry_t mem_q [DEPTH];

    // Entry storage; cleared on reset so an unprogrammed profile writes zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/pwm_sequencer.sv
// Steps through a compare-value profile, writing COMPARE1/COMPARE2 into the PWM register
// file once per entry, and merges those writes with SPI writes (SPI has fixed priority).
module pwm_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_wr_req,
    input  logic [5:0]       spi_addr,
    input  logic [7:0]       spi_wdata,
    output logic             reg_wr_en,
    output logic [5:0]       reg_addr,
    output logic [7:0]       reg_wdata,
    input  logic             seq_en,
    input  logic             tbl_we,
    input  logic [IDX_W-1:0] tbl_idx,
    input  logic [7:0]       tbl_c1,
    input  logic [7:0]       tbl_c2,
    input  logic [7:0]       tbl_rep,
    input  logic [IDX_W-1:0] tbl_last,
    input  logic             period_wrap,
    output logic             seq_busy,
    output logic [IDX_W-1:0] seq_idx,
    output logic             seq_done
);

    seq_state_e       state_q;
    logic [IDX_W-1:0] seq_idx_q;
    logic [IDX_W-1:0] last_q;
    logic [7:0]       rep_q;
    logic             pend_q;
    logic             seq_done_q;

    logic             reg_wr_en_q;
    logic [5:0]       reg_addr_q;
    logic [7:0]       reg_wdata_q;

    logic             tbl_wr;
    tbl_entry_t       tbl_wr_data;
    logic [IDX_W-1:0] rd_idx;
    tbl_entry_t       rd_entry;

    logic             seq_grant;
    logic [5:0]       seq_addr;
    logic [7:0]       seq_data;
    logic             wrap_evt;
    logic             at_last;
    logic [IDX_W-1:0] next_idx;

    // Table is only writable while the sequencer is parked
    assign tbl_wr      = tbl_we && (state_q == StIdle);
    assign tbl_wr_data = pack_entry(tbl_c1, tbl_c2, tbl_rep);

    pwm_seq_table #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tbl_wr),
        .wr_idx  (tbl_idx),
        .wr_data (tbl_wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_entry)
    );

    // Arbitration, next-entry computation and the single shared table read index
    always_comb begin
        at_last   = (seq_idx_q == last_q);
        next_idx  = at_last ? '0 : seq_idx_q + IDX_W'(1);
        wrap_evt  = period_wrap || pend_q;
        seq_grant = seq_en && !spi_wr_req && ((state_q == StWrC1) || (state_q == StWrC2));
        seq_addr  = (state_q == StWrC2) ? REG_COMPARE2 : REG_COMPARE1;
        seq_data  = (state_q == StWrC2) ? rd_entry.c2 : rd_entry.c1;
        // The read port serves the entry being loaded in IDLE/WAIT_WRAP, else the current one
        unique case (state_q)
            StIdle:     rd_idx = '0;
            StWaitWrap: rd_idx = next_idx;
            default:    rd_idx = seq_idx_q;
        endcase
    end

    // Register-file write port: one accepted write per cycle, presented one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_en_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            reg_wr_en_q <= spi_wr_req || seq_grant;
            if (spi_wr_req) begin
                reg_addr_q  <= spi_addr;
                reg_wdata_q <= spi_wdata;
            end else if (seq_grant) begin
                reg_addr_q  <= seq_addr;
                reg_wdata_q <= seq_data;
            end
        end
    end

    // Sequencer FSM: entry load, compare writes, period counting and wrap bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            seq_idx_q  <= '0;
            last_q     <= '0;
            rep_q      <= '0;
            pend_q     <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            seq_done_q <= 1'b0;
            if (!seq_en) begin
                state_q <= StIdle;
                pend_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        seq_idx_q <= '0;
                        rep_q     <= rd_entry.rep;
                        last_q    <= tbl_last;
                        pend_q    <= 1'b0;
                        state_q   <= StWrC1;
                    end
                    StWrC1: begin
                        // Wraps during the write phase are remembered once; extras are lost
                        if (period_wrap) pend_q <= 1'b1;
                        if (!spi_wr_req) state_q <= StWrC2;
                    end
                    StWrC2: begin
                        if (period_wrap) pend_q <= 1'b1;
                        if (!spi_wr_req) state_q <= StWaitWrap;
                    end
                    StWaitWrap: begin
                        if (wrap_evt) begin
                            pend_q <= 1'b0;
                            if (rep_q != 8'd0) begin
                                rep_q <= rep_q - 8'd1;
                            end else begin
                                seq_idx_q  <= next_idx;
                                rep_q      <= rd_entry.rep;
                                last_q     <= tbl_last;
                                seq_done_q <= at_last;
                                state_q    <= StWrC1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign reg_wr_en = reg_wr_en_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign seq_busy  = (state_q != StIdle);
    assign seq_idx   = seq_idx_q;
    assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: profile playback, SPI priority, pending wrap,
// enable drop, table write protection and asynchronous reset.
module tb_pwm_sequencer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             spi_wr_req;
    logic [5:0]       spi_addr;
    logic [7:0]       spi_wdata;
    logic             reg_wr_en;
    logic [5:0]       reg_addr;
    logic [7:0]       reg_wdata;
    logic             seq_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_idx;
    logic [7:0]       tbl_c1;
    logic [7:0]       tbl_c2;
    logic [7:0]       tbl_rep;
    logic [IDX_W-1:0] tbl_last;
    logic             period_wrap;
    logic             seq_busy;
    logic [IDX_W-1:0] seq_idx;
    logic             seq_done;

    int checks = 0;
    int errors = 0;

    pwm_sequencer #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_wr_req  (spi_wr_req),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .seq_en      (seq_en),
        .tbl_we      (tbl_we),
        .tbl_idx     (tbl_idx),
        .tbl_c1      (tbl_c1),
        .tbl_c2      (tbl_c2),
        .tbl_rep     (tbl_rep),
        .tbl_last    (tbl_last),
        .period_wrap (period_wrap),
        .seq_busy    (seq_busy),
        .seq_idx     (seq_idx),
        .seq_done    (seq_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [5:0] addr, input logic [7:0] data);
        check_eq({tag, "_en"}, 32'(reg_wr_en), 1);
        check_eq({tag, "_addr"}, 32'(reg_addr), 32'(addr));
        check_eq({tag, "_data"}, 32'(reg_wdata), 32'(data));
    endtask

    task automatic chk_no_wr(input string tag);
        check_eq({tag, "_en"}, 32'(reg_wr_en), 0);
    endtask

    task automatic tbl_write(input logic [IDX_W-1:0] idx, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] rep);
        tbl_we  = 1'b1;
        tbl_idx = idx;
        tbl_c1  = c1;
        tbl_c2  = c2;
        tbl_rep = rep;
        step();
        tbl_we  = 1'b0;
    endtask

    task automatic spi_push(input logic [5:0] addr, input logic [7:0] data);
        spi_wr_req = 1'b1;
        spi_addr   = addr;
        spi_wdata  = data;
        step();
    endtask

    task automatic wrap_pulse();
        period_wrap = 1'b1;
        step();
        period_wrap = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        spi_wr_req  = 1'b0;
        spi_addr    = '0;
        spi_wdata   = '0;
        seq_en      = 1'b0;
        tbl_we      = 1'b0;
        tbl_idx     = '0;
        tbl_c1      = '0;
        tbl_c2      = '0;
        tbl_rep     = '0;
        tbl_last    = '0;
        period_wrap = 1'b0;

        // Reset state
        #1;
        check_eq("rst_wr_en", 32'(reg_wr_en), 0);
        check_eq("rst_addr", 32'(reg_addr), 0);
        check_eq("rst_wdata", 32'(reg_wdata), 0);
        check_eq("rst_busy", 32'(seq_busy), 0);
        check_eq("rst_idx", 32'(seq_idx), 0);
        check_eq("rst_done", 32'(seq_done), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Profile: entry0 {2,6,rep0}, entry1 {5,5,rep1}, two-entry loop
        tbl_write(3'd0, 8'd2, 8'd6, 8'd0);
        tbl_write(3'd1, 8'd5, 8'd5, 8'd1);
        tbl_last = 3'd1;
        chk_no_wr("idle_quiet");
        check_eq("idle_busy", 32'(seq_busy), 0);

        seq_en = 1'b1;
        step();
        check_eq("start_busy", 32'(seq_busy), 1);
        check_eq("start_idx", 32'(seq_idx), 0);
        chk_no_wr("start_quiet");
        step();
        chk_wr("e0_c1", 6'h03, 8'd2);
        step();
        chk_wr("e0_c2", 6'h05, 8'd6);
        step();
        chk_no_wr("e0_wait");
        check_eq("e0_wait_busy", 32'(seq_busy), 1);

        // rep=0: one wrap advances to entry 1
        wrap_pulse();
        check_eq("adv1_idx", 32'(seq_idx), 1);
        check_eq("adv1_done", 32'(seq_done), 0);
        step();
        chk_wr("e1_c1", 6'h03, 8'd5);
        step();
        chk_wr("e1_c2", 6'h05, 8'd5);

        // rep=1: first wrap only counts down
        wrap_pulse();
        check_eq("e1_hold_idx", 32'(seq_idx), 1);
        chk_no_wr("e1_hold_quiet");
        step();
        chk_no_wr("e1_hold_quiet2");
        wrap_pulse();
        check_eq("loop_idx", 32'(seq_idx), 0);
        check_eq("loop_done", 32'(seq_done), 1);

        // SPI burst of three writes while the sequencer sits in WR_C1
        spi_push(6'h10, 8'hA0);
        chk_wr("spi0", 6'h10, 8'hA0);
        check_eq("done_pulse_end", 32'(seq_done), 0);
        spi_push(6'h11, 8'hA1);
        chk_wr("spi1", 6'h11, 8'hA1);
        spi_push(6'h12, 8'hA2);
        chk_wr("spi2", 6'h12, 8'hA2);
        spi_wr_req = 1'b0;
        step();
        chk_wr("after_spi_c1", 6'h03, 8'd2);

        // Wrap arrives in WR_C2: serviced on the first WAIT_WRAP cycle
        wrap_pulse();
        chk_wr("pend_c2", 6'h05, 8'd6);
        check_eq("pend_not_yet_idx", 32'(seq_idx), 0);
        step();
        check_eq("pend_adv_idx", 32'(seq_idx), 1);
        check_eq("pend_adv_done", 32'(seq_done), 0);
        chk_no_wr("pend_adv_quiet");
        step();
        chk_wr("pend_e1_c1", 6'h03, 8'd5);

        // Enable dropped in WR_C2: no COMPARE2 write, IDLE next cycle
        seq_en = 1'b0;
        step();
        chk_no_wr("drop_no_c2");
        check_eq("drop_busy", 32'(seq_busy), 0);
        step();
        chk_no_wr("drop_quiet");

        // Table writes are ignored while busy
        seq_en = 1'b1;
        step();
        tbl_write(3'd0, 8'h77, 8'h88, 8'h09);
        chk_wr("prot_c1", 6'h03, 8'd2);
        step();
        chk_wr("prot_c2", 6'h05, 8'd6);

        // Asynchronous reset while a write strobe is on the output
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_wr_en", 32'(reg_wr_en), 0);
        check_eq("arst_addr", 32'(reg_addr), 0);
        check_eq("arst_wdata", 32'(reg_wdata), 0);
        check_eq("arst_busy", 32'(seq_busy), 0);
        check_eq("arst_idx", 32'(seq_idx), 0);
        check_eq("arst_done", 32'(seq_done), 0);
        seq_en = 1'b0;
        step();
        chk_no_wr("arst_hold");
        rst_n = 1'b1;
        step();
        chk_no_wr("arst_release");

        // Cleared table with a one-entry loop: zeros written, seq_done on every advance
        tbl_last = 3'd0;
        seq_en   = 1'b1;
        step();
        step();
        chk_wr("clr_c1", 6'h03, 8'd0);
        step();
        chk_wr("clr_c2", 6'h05, 8'd0);
        wrap_pulse();
        check_eq("one_idx", 32'(seq_idx), 0);
        check_eq("one_done", 32'(seq_done), 1);
        check_eq("one_busy", 32'(seq_busy), 1);
        step();
        check_eq("one_done_end", 32'(seq_done), 0);
        chk_wr("one_c1", 6'h03, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: number of profile table entries (power of two).
REQ-002 Parameter IDX_W, default 3: table index width, $clog2(DEPTH).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 spi_wr_req  input  1  single-cycle write strobe from the SPI bridge.
REQ-006 spi_addr  input  6  SPI write register address.
REQ-007 spi_wdata  input  8  SPI write data.
REQ-008 reg_wr_en  output  1  registered write strobe to the PWM register file.
REQ-009 reg_addr  output  6  registered write address.
REQ-010 reg_wdata  output  8  registered write data.
REQ-011 seq_en  input  1  level; 1 runs the sequencer, 0 stops it.
REQ-012 tbl_we  input  1  table entry write strobe.
REQ-013 tbl_idx  input  IDX_W  table entry index.
REQ-014 tbl_c1, tbl_c2, tbl_rep  input  8 each  compare1, compare2 and repeat count for the entry.
REQ-015 tbl_last  input  IDX_W  index of the final active entry; sampled when an entry is loaded.
REQ-016 period_wrap  input  1  single-cycle pulse from the PWM counter at period wrap.
REQ-017 seq_busy  output  1  high in every state except IDLE.
REQ-018 seq_idx  output  IDX_W  index of the current entry.
REQ-019 seq_done  output  1  one-cycle pulse when the sequence wraps from tbl_last back to 0.

Function
REQ-020 FSM states: IDLE, WR_C1, WR_C2, WAIT_WRAP.
REQ-021 IDLE with seq_en=1 -> load entry 0 (seq_idx=0, rep_cnt=tbl_rep[0]) -> WR_C1.
REQ-022 WR_C1 issues write addr 0x03, data c1[seq_idx] -> WR_C2 once granted.
REQ-023 WR_C2 issues write addr 0x05, data c2[seq_idx] -> WAIT_WRAP once granted.
REQ-024 Arbitration: SPI has fixed priority; a cycle with spi_wr_req=1 forwards the SPI write, and the sequencer write stalls in its state.
REQ-025 Every accepted write appears on reg_wr_en/reg_addr/reg_wdata exactly 1 cycle after acceptance; at most one write per cycle; SPI writes are never dropped.
REQ-026 WAIT_WRAP on period_wrap (or a pending wrap): rep_cnt>0 -> decrement, stay; rep_cnt=0 -> advance entry -> WR_C1.
REQ-027 Each entry is held for tbl_rep+1 periods.
REQ-028 Advance: seq_idx==tbl_last -> seq_idx=0 and seq_done pulses in the same cycle; otherwise seq_idx+1. Load the new rep_cnt.
REQ-029 period_wrap during WR_C1/WR_C2 sets a sticky pending bit, serviced on the first WAIT_WRAP cycle; additional wraps before service are lost.
REQ-030 seq_en=0 in any state -> IDLE on the next edge; no sequencer write is accepted in a cycle with seq_en=0; pending bit clears.
REQ-031 tbl_we is ignored while seq_busy=1; in IDLE it writes the entry in 1 cycle.
REQ-032 tbl_last > DEPTH-1 is impossible by width; tbl_last=0 gives a one-entry loop that pulses seq_done on every advance.

Reset
REQ-033 rst_n low: state=IDLE; seq_idx, rep_cnt, pending bit, reg_wr_en, reg_addr, reg_wdata, seq_busy and seq_done = 0.
REQ-034 Table contents are reset to 0.
REQ-035 Reset asserted mid-write aborts it; no write strobe appears after reset.

Structure
REQ-036 Shared package pwm_pkg holds the register address constants (REG_COMPARE1=6'h03, REG_COMPARE2=6'h05 and the rest of the map) and the sequencer state enum.
REQ-037 Single sub-module pwm_seq_table: DEPTH x 24-bit register array with one write port and asynchronous read.

Verification
REQ-038 Load entries {c1=2,c2=6,rep=0} and {c1=5,c2=5,rep=1}, tbl_last=1, set seq_en -> writes 0x03=2 and 0x05=6; after 1 wrap, 0x03=5 and 0x05=5; after 2 more wraps, entry 0 again with seq_done=1.
REQ-039 Hold spi_wr_req=1 for 3 cycles during WR_C1 -> 3 SPI writes forwarded in order, then the sequencer writes 0x03; no writes are lost.
REQ-040 period_wrap pulse while in WR_C2 -> entry advances immediately after entering WAIT_WRAP.
REQ-041 Drop seq_en in WR_C2 -> no 0x05 write; IDLE next cycle; seq_busy=0.
REQ-042 Assert rst_n=0 mid-sequence -> all outputs 0 asynchronously; tbl_we while busy leaves the table unchanged.
